cache_mem_arbiter: RTL and testbench



---
 rtl/cache_mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// Purpose: shares one burst memory port between I-cache, D-cache and prefetcher; whole-line reads/writebacks as 64-bit beats.
// Latency: command 1 cycle after grant; resp 1 cycle after the last read beat is captured or the last write beat is accepted.
// Backpressure: command and write beats hold until bmem_ready; read beats are taken only when rvalid and the address tag match.
module cache_mem_arbiter #(
  parameter int LINE_SIZE = 256,
  parameter int BEAT_SIZE = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_read,
  input  logic [31:0]          i_addr,
  output logic [LINE_SIZE-1:0] i_rdata,
  output logic                 i_resp,
  output logic                 i_in_service,
  input  logic                 d_read,
  input  logic                 d_write,
  input  logic [31:0]          d_addr,
  input  logic [LINE_SIZE-1:0] d_wdata,
  output logic [LINE_SIZE-1:0] d_rdata,
  output logic                 d_resp,
  output logic                 d_in_service,
  input  logic                 pf_read,
  input  logic [31:0]          pf_addr,
  output logic [LINE_SIZE-1:0] pf_rdata,
  output logic                 pf_resp,
  output logic [31:0]          bmem_addr,
  output logic                 bmem_read,
  output logic                 bmem_write,
  output logic [BEAT_SIZE-1:0] bmem_wdata,
  input  logic                 bmem_ready,
  input  logic [31:0]          bmem_raddr,
  input  logic [BEAT_SIZE-1:0] bmem_rdata,
  input  logic                 bmem_rvalid
);

  localparam int BEATS = LINE_SIZE / BEAT_SIZE;
  localparam int CNT_W = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [31:0]      OFF_MASK  = 32'(LINE_SIZE / 8 - 1);

  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WR_BURST, RESP} state_t;
  typedef enum logic [1:0] {REQ_I, REQ_D, REQ_P} req_t;

  state_t                 state_q, state_d;
  req_t                   gnt_q, gnt_d;
  logic                   last_d_q, last_d_d;   // 1: the D-cache won the last cache grant
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [31:0]            addr_q, addr_d;
  logic [LINE_SIZE-1:0]   rbuf_q, rbuf_d;
  logic [LINE_SIZE-1:0]   wbuf_q, wbuf_d;

  logic i_req, d_req;
  assign i_req = i_read;
  assign d_req = d_read | d_write;

  // Arbitration, burst sequencing and beat assembly.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    last_d_d = last_d_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    rbuf_d   = rbuf_q;
    wbuf_d   = wbuf_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // Caches alternate on contention; the prefetcher only fills idle gaps and leaves the rotation alone.
        if (i_req && (!d_req || last_d_q)) begin
          gnt_d    = REQ_I;
          addr_d   = i_addr & ~OFF_MASK;
          last_d_d = 1'b0;
          state_d  = RD_ISSUE;
        end else if (d_req) begin
          gnt_d    = REQ_D;
          addr_d   = d_addr & ~OFF_MASK;
          last_d_d = 1'b1;
          if (d_write) begin
            wbuf_d  = d_wdata;
            state_d = WR_BURST;
          end else begin
            state_d = RD_ISSUE;
          end
        end else if (pf_read) begin
          gnt_d   = REQ_P;
          addr_d  = pf_addr & ~OFF_MASK;
          state_d = RD_ISSUE;
        end
      end
      RD_ISSUE: begin
        if (bmem_ready) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        // Beats tagged for another line belong to someone else and are dropped.
        if (bmem_rvalid && (bmem_raddr == addr_q)) begin
          rbuf_d[32'(cnt_q) * BEAT_SIZE +: BEAT_SIZE] = bmem_rdata;
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == LAST_BEAT) state_d = RESP;
        end
      end
      WR_BURST: begin
        if (bmem_ready) begin
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == LAST_BEAT) state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any transfer in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      gnt_q    <= REQ_I;
      last_d_q <= 1'b1;
      cnt_q    <= '0;
      addr_q   <= '0;
      rbuf_q   <= '0;
      wbuf_q   <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      last_d_q <= last_d_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      rbuf_q   <= rbuf_d;
      wbuf_q   <= wbuf_d;
    end
  end

  assign i_resp       = (state_q == RESP) && (gnt_q == REQ_I);
  assign d_resp       = (state_q == RESP) && (gnt_q == REQ_D);
  assign pf_resp      = (state_q == RESP) && (gnt_q == REQ_P);
  assign i_in_service = (state_q != IDLE) && (gnt_q == REQ_I);
  assign d_in_service = (state_q != IDLE) && (gnt_q == REQ_D);
  assign i_rdata      = rbuf_q;
  assign d_rdata      = rbuf_q;
  assign pf_rdata     = rbuf_q;
  assign bmem_addr    = addr_q;
  assign bmem_read    = (state_q == RD_ISSUE);
  assign bmem_write   = (state_q == WR_BURST);
  assign bmem_wdata   = (state_q == WR_BURST) ? wbuf_q[32'(cnt_q) * BEAT_SIZE +: BEAT_SIZE] : '0;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
module tb_cache_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         i_read, d_read, d_write, pf_read;
  logic [31:0]  i_addr, d_addr, pf_addr;
  logic [255:0] d_wdata;
  logic [255:0] i_rdata, d_rdata, pf_rdata;
  logic         i_resp, d_resp, pf_resp, i_in_service, d_in_service;
  logic [31:0]  bmem_addr, bmem_raddr;
  logic         bmem_read, bmem_write, bmem_ready, bmem_rvalid;
  logic [63:0]  bmem_wdata, bmem_rdata;

  int total = 0;
  int bad   = 0;

  logic [255:0] mem_model [logic [31:0]];

  cache_mem_arbiter #(.LINE_SIZE(256), .BEAT_SIZE(64)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp), .i_in_service(i_in_service),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
    .d_resp(d_resp), .d_in_service(d_in_service),
    .pf_read(pf_read), .pf_addr(pf_addr), .pf_rdata(pf_rdata), .pf_resp(pf_resp),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write), .bmem_wdata(bmem_wdata),
    .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr), .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    i_read = 0; d_read = 0; d_write = 0; pf_read = 0;
    i_addr = 0; d_addr = 0; pf_addr = 0; d_wdata = '0;
    bmem_ready = 0; bmem_raddr = 0; bmem_rdata = 0; bmem_rvalid = 0;
  endtask

  task automatic do_reset;
    clear_inputs();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // Default content of a line never written: a function of its address.
  function automatic logic [255:0] line_at(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return {~a, a + 32'd3, ~a, a + 32'd2, ~a, a + 32'd1, ~a, a};
  endfunction

  task automatic test_reset;
    clear_inputs();
    rst = 1'b0;
    #3;
    total++;
    if ({i_resp, d_resp, pf_resp, i_in_service, d_in_service, bmem_read, bmem_write} !== 7'b0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b exp=0000000", {i_resp, d_resp, pf_resp, i_in_service, d_in_service, bmem_read, bmem_write});
    end
    total++;
    if (bmem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=00000000", bmem_addr); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    tick();
    total++;
    if ({bmem_read, bmem_write, i_in_service, d_in_service} !== 4'b0) begin
      bad++; $display("FAIL reset_idle got=%b exp=0000", {bmem_read, bmem_write, i_in_service, d_in_service});
    end
  endtask

  task automatic test_read_basic;
    logic [255:0] line;
    line = {64'hD, 64'hC, 64'hB, 64'hA};
    i_read = 1; i_addr = 32'h0000_1234; bmem_ready = 1;
    tick(); // T+1
    total++;
    if (bmem_read !== 1'b1 || bmem_addr !== 32'h0000_1220) begin
      bad++; $display("FAIL rd_issue read=%b addr=%h exp read=1 addr=00001220", bmem_read, bmem_addr);
    end
    total++;
    if (i_in_service !== 1'b1) begin bad++; $display("FAIL rd_in_service_rise got=%b exp=1", i_in_service); end
    tick(); // T+2
    total++;
    if (bmem_read !== 1'b0) begin bad++; $display("FAIL rd_wait_read got=%b exp=0", bmem_read); end
    tick(); // T+3
    for (int k = 0; k < 4; k++) begin
      total++;
      if (i_resp !== 1'b0) begin bad++; $display("FAIL rd_early_resp beat=%0d got=%b exp=0", k, i_resp); end
      bmem_rvalid = 1; bmem_raddr = 32'h0000_1220; bmem_rdata = line[64*k +: 64];
      tick();
    end
    bmem_rvalid = 0;
    total++;
    if (i_resp !== 1'b1 || i_in_service !== 1'b1) begin
      bad++; $display("FAIL rd_resp resp=%b in_service=%b exp 1 1", i_resp, i_in_service);
    end
    total++;
    if (i_rdata !== line) begin bad++; $display("FAIL rd_data got=%h exp=%h", i_rdata, line); end
    i_read = 0;
    tick();
    total++;
    if (i_resp !== 1'b0 || i_in_service !== 1'b0) begin
      bad++; $display("FAIL rd_after_resp resp=%b in_service=%b exp 0 0", i_resp, i_in_service);
    end
  endtask

  task automatic test_write_basic;
    logic [255:0] w;
    w = {64'h4, 64'h3, 64'h2, 64'h1};
    d_write = 1; d_addr = 32'h80; d_wdata = w; bmem_ready = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      total++;
      if (bmem_write !== 1'b1 || bmem_wdata !== 64'(k + 1) || bmem_addr !== 32'h80 || d_resp !== 1'b0) begin
        bad++;
        $display("FAIL wr_beat k=%0d write=%b wdata=%h addr=%h resp=%b exp 1 %h 00000080 0",
                 k, bmem_write, bmem_wdata, bmem_addr, d_resp, 64'(k + 1));
      end
    end
    tick(); // T+5
    total++;
    if (d_resp !== 1'b1 || d_in_service !== 1'b1 || bmem_write !== 1'b0) begin
      bad++; $display("FAIL wr_resp resp=%b in_service=%b write=%b exp 1 1 0", d_resp, d_in_service, bmem_write);
    end
    d_write = 0;
    tick();
    total++;
    if (d_resp !== 1'b0 || d_in_service !== 1'b0) begin
      bad++; $display("FAIL wr_after_resp resp=%b in_service=%b exp 0 0", d_resp, d_in_service);
    end
    bmem_ready = 0;
  endtask

  task automatic test_arbitration;
    logic [31:0]  ea [4];
    int           who [4];
    logic [255:0] line, got;
    logic [2:0]   exp_resp;
    logic [1:0]   exp_is;
    int           t;
    ea  = '{32'h100, 32'h200, 32'h300, 32'h400};
    who = '{0, 1, 0, 2};
    do_reset();
    i_read = 1; i_addr = 32'h104; d_read = 1; d_addr = 32'h21F; pf_read = 1; pf_addr = 32'h400;
    bmem_ready = 1;
    for (int g = 0; g < 4; g++) begin
      t = 0;
      tick();
      while (bmem_read !== 1'b1 && t < 20) begin tick(); t++; end
      exp_is = (who[g] == 0) ? 2'b10 : (who[g] == 1) ? 2'b01 : 2'b00;
      total++;
      if (bmem_read !== 1'b1 || bmem_addr !== ea[g] || {i_in_service, d_in_service} !== exp_is) begin
        bad++;
        $display("FAIL arb_grant g=%0d read=%b addr=%h is=%b exp 1 %h %b", g, bmem_read, bmem_addr,
                 {i_in_service, d_in_service}, ea[g], exp_is);
      end
      tick();
      line = {ea[g] + 32'd3, 32'hA0 + 32'(g), ea[g] + 32'd2, 32'hB0, ea[g] + 32'd1, 32'hC0, ea[g], 32'hD0 + 32'(g)};
      for (int k = 0; k < 4; k++) begin
        bmem_rvalid = 1; bmem_raddr = ea[g]; bmem_rdata = line[64*k +: 64];
        tick();
      end
      bmem_rvalid = 0;
      exp_resp = 3'b100 >> who[g];
      total++;
      if ({i_resp, d_resp, pf_resp} !== exp_resp) begin
        bad++; $display("FAIL arb_resp g=%0d got=%b exp=%b", g, {i_resp, d_resp, pf_resp}, exp_resp);
      end
      got = (who[g] == 0) ? i_rdata : (who[g] == 1) ? d_rdata : pf_rdata;
      total++;
      if (got !== line) begin bad++; $display("FAIL arb_data g=%0d got=%h exp=%h", g, got, line); end
      case (g)
        0: i_addr = 32'h31C;
        1: d_read = 0;
        2: i_read = 0;
        default: pf_read = 0;
      endcase
    end
    tick();
    bmem_ready = 0;
  endtask

  task automatic test_ready_stall;
    logic [255:0] line;
    line = {64'h1111_4444, 64'h1111_3333, 64'h1111_2222, 64'h1111_1111};
    i_read = 1; i_addr = 32'h547; bmem_ready = 0;
    tick();
    for (int s = 0; s < 4; s++) begin
      total++;
      if (bmem_read !== 1'b1 || bmem_addr !== 32'h540) begin
        bad++; $display("FAIL stall_hold s=%0d read=%b addr=%h exp 1 00000540", s, bmem_read, bmem_addr);
      end
      bmem_rvalid = (s < 3); bmem_raddr = 32'h540; bmem_rdata = 64'hBAD0 + 64'(s);
      if (s == 3) bmem_ready = 1;
      tick();
    end
    bmem_ready = 0;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (i_resp !== 1'b0) begin bad++; $display("FAIL stall_early_resp k=%0d got=%b exp=0", k, i_resp); end
      bmem_rvalid = 1; bmem_raddr = 32'h540; bmem_rdata = line[64*k +: 64];
      tick();
    end
    bmem_rvalid = 0;
    total++;
    if (i_resp !== 1'b1 || i_rdata !== line) begin
      bad++; $display("FAIL stall_resp resp=%b data=%h exp 1 %h", i_resp, i_rdata, line);
    end
    i_read = 0;
    tick();
  endtask

  task automatic test_drop_beats;
    int           kind [7];
    int           k;
    logic [255:0] line;
    kind = '{0, 1, 0, 2, 0, 1, 0};
    line = {64'h4D, 64'h3D, 64'h2D, 64'h1D};
    // Stray beats tagged with the current latched address while idle.
    for (int s = 0; s < 2; s++) begin
      bmem_rvalid = 1; bmem_raddr = 32'h540; bmem_rdata = 64'hDEAD;
      tick();
    end
    bmem_rvalid = 0;
    d_read = 1; d_addr = 32'h600; bmem_ready = 1;
    tick();
    tick();
    bmem_ready = 0;
    k = 0;
    for (int s = 0; s < 7; s++) begin
      total++;
      if (d_resp !== 1'b0) begin bad++; $display("FAIL drop_early_resp s=%0d got=%b exp=0", s, d_resp); end
      bmem_rvalid = (kind[s] != 2);
      bmem_raddr  = (kind[s] == 1) ? 32'h620 : 32'h600;
      bmem_rdata  = (kind[s] == 0) ? line[64*k +: 64] : 64'hFFFF_0000_DEAD_BEEF;
      if (kind[s] == 0) k++;
      tick();
    end
    bmem_rvalid = 0;
    total++;
    if (d_resp !== 1'b1 || d_rdata !== line) begin
      bad++; $display("FAIL drop_resp resp=%b data=%h exp 1 %h", d_resp, d_rdata, line);
    end
    d_read = 0;
    tick();
  endtask

  task automatic test_reset_midburst;
    logic [255:0] w, w2;
    w  = {64'hA4, 64'hA3, 64'hA2, 64'hA1};
    w2 = {64'hC4, 64'hC3, 64'hC2, 64'hC1};
    d_write = 1; d_addr = 32'hA0; d_wdata = w; bmem_ready = 1;
    repeat (4) tick();
    total++;
    if (bmem_write !== 1'b1 || bmem_wdata !== 64'hA4) begin
      bad++; $display("FAIL rstmid_beat3 write=%b wdata=%h exp 1 00000000000000a4", bmem_write, bmem_wdata);
    end
    #2 rst = 1'b0;
    #1;
    total++;
    if ({bmem_write, bmem_read, d_in_service, d_resp} !== 4'b0 || bmem_addr !== 32'h0) begin
      bad++;
      $display("FAIL rstmid_async ctrl=%b addr=%h exp 0000 00000000", {bmem_write, bmem_read, d_in_service, d_resp}, bmem_addr);
    end
    d_write = 0;
    @(posedge clk);
    #1 rst = 1'b1;
    for (int s = 0; s < 3; s++) begin
      bmem_rvalid = 1; bmem_raddr = 32'hA0; bmem_rdata = 64'h1A7E;
      tick();
      total++;
      if ({d_resp, bmem_write, bmem_read, d_in_service} !== 4'b0) begin
        bad++; $display("FAIL rstmid_idle s=%0d got=%b exp=0000", s, {d_resp, bmem_write, bmem_read, d_in_service});
      end
    end
    bmem_rvalid = 0;
    d_write = 1; d_addr = 32'hC0; d_wdata = w2;
    tick();
    total++;
    if (bmem_write !== 1'b1 || bmem_wdata !== 64'hC1 || bmem_addr !== 32'hC0) begin
      bad++; $display("FAIL rstmid_restart write=%b wdata=%h addr=%h exp 1 c1 000000c0", bmem_write, bmem_wdata, bmem_addr);
    end
    repeat (4) tick();
    total++;
    if (d_resp !== 1'b1) begin bad++; $display("FAIL rstmid_resp got=%b exp=1", d_resp); end
    d_write = 0; bmem_ready = 0;
    tick();
  endtask

  // Random traffic against a transaction-level model: arbitration order, line contents and handshake timing.
  task automatic test_random;
    bit           act [3];
    bit           wr [3];
    logic [31:0]  raddr_req [3];
    logic [255:0] wd [3];
    bit           free, busy, after_resp, idle_cur, last_d, rd_acc, rd_phase, resp_due, own_wr, drain, rdy;
    int           owner, wcnt, rcnt;
    logic [31:0]  own_addr;
    logic [255:0] own_line, own_wd, got;
    logic [2:0]   exp_resp;
    logic [1:0]   exp_is, exp_cmd;
    do_reset();
    for (int x = 0; x < 3; x++) begin act[x] = 0; wr[x] = 0; raddr_req[x] = 0; wd[x] = '0; end
    free = 0; busy = 0; after_resp = 1; last_d = 1; rd_acc = 0; rd_phase = 0; resp_due = 0;
    own_wr = 0; owner = 0; wcnt = 0; rcnt = 0; own_addr = 0; own_line = '0; own_wd = '0;
    for (int cyc = 0; cyc < 1800; cyc++) begin
      drain = (cyc >= 1300);
      if (drain && !busy && !act[0] && !act[1] && !act[2]) break;
      idle_cur = 0;
      if (after_resp) begin
        idle_cur = 1; after_resp = 0;
      end else if (free) begin
        if (act[0] || act[1] || act[2]) begin
          if (act[0] && (!act[1] || last_d)) owner = 0;
          else if (act[1]) owner = 1;
          else owner = 2;
          if (owner != 2) last_d = (owner == 1);
          busy = 1; own_addr = raddr_req[owner] & ~32'h1F; own_wr = (owner == 1) && wr[1];
          own_wd = wd[1]; own_line = line_at(own_addr);
          rd_acc = 0; rd_phase = 0; wcnt = 0; rcnt = 0; resp_due = 0;
        end else begin
          idle_cur = 1;
        end
      end
      exp_is = {busy && owner == 0, busy && owner == 1};
      total++;
      if ({i_in_service, d_in_service} !== exp_is) begin
        bad++; $display("FAIL rnd_in_service cyc=%0d got=%b exp=%b", cyc, {i_in_service, d_in_service}, exp_is);
      end
      exp_cmd = {busy && !own_wr && !rd_acc, busy && own_wr && wcnt < 4};
      total++;
      if ({bmem_read, bmem_write} !== exp_cmd || (exp_cmd != 2'b00 && bmem_addr !== own_addr)) begin
        bad++;
        $display("FAIL rnd_cmd cyc=%0d rw=%b addr=%h exp rw=%b addr=%h", cyc, {bmem_read, bmem_write}, bmem_addr, exp_cmd, own_addr);
      end
      exp_resp = resp_due ? (3'b100 >> owner) : 3'b000;
      total++;
      if ({i_resp, d_resp, pf_resp} !== exp_resp) begin
        bad++; $display("FAIL rnd_resp cyc=%0d got=%b exp=%b", cyc, {i_resp, d_resp, pf_resp}, exp_resp);
      end
      if (resp_due) begin
        if (!own_wr) begin
          got = (owner == 0) ? i_rdata : (owner == 1) ? d_rdata : pf_rdata;
          total++;
          if (got !== own_line) begin bad++; $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", cyc, got, own_line); end
        end else begin
          mem_model[own_addr] = own_wd;
        end
        act[owner] = 0; busy = 0; resp_due = 0; after_resp = 1;
      end
      free = idle_cur;
      // Memory side for the coming edge.
      rdy = ($urandom_range(0, 3) != 0);
      bmem_ready = rdy;
      bmem_rvalid = 0; bmem_raddr = $urandom; bmem_rdata = {$urandom, $urandom};
      if (rd_phase) begin
        case ($urandom_range(0, 4))
          0, 1, 2: begin
            bmem_rvalid = 1; bmem_raddr = own_addr; bmem_rdata = own_line[64*rcnt +: 64];
            rcnt++;
            if (rcnt == 4) begin resp_due = 1; rd_phase = 0; end
          end
          3: begin bmem_rvalid = 1; bmem_raddr = own_addr ^ 32'h20; end
          default: ;
        endcase
      end else if ($urandom_range(0, 3) == 0) begin
        bmem_rvalid = 1;
        if (busy) bmem_raddr = own_addr;
      end
      if (busy && !own_wr && !rd_acc && rdy) begin rd_acc = 1; rd_phase = 1; end
      if (busy && own_wr && wcnt < 4 && rdy) begin
        total++;
        if (bmem_wdata !== own_wd[64*wcnt +: 64]) begin
          bad++; $display("FAIL rnd_wdata cyc=%0d beat=%0d got=%h exp=%h", cyc, wcnt, bmem_wdata, own_wd[64*wcnt +: 64]);
        end
        wcnt++;
        if (wcnt == 4) resp_due = 1;
      end
      for (int x = 0; x < 3; x++) begin
        if (!act[x] && !drain && $urandom_range(0, 3) == 0) begin
          act[x] = 1;
          raddr_req[x] = 32'h0001_0000 + (32'($urandom_range(0, 7)) << 5) + 32'($urandom_range(0, 31));
          wr[x] = (x == 1) && ($urandom_range(0, 2) == 0);
          wd[x] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        end
      end
      i_read = act[0]; i_addr = raddr_req[0];
      d_read = act[1] && !wr[1]; d_write = act[1] && wr[1]; d_addr = raddr_req[1]; d_wdata = wd[1];
      pf_read = act[2]; pf_addr = raddr_req[2];
      tick();
    end
    total++;
    if (busy || act[0] || act[1] || act[2]) begin
      bad++; $display("FAIL rnd_drain busy=%b pending=%b%b%b exp 0 000", busy, act[0], act[1], act[2]);
    end
    clear_inputs();
    tick();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_read_basic();
    test_write_basic();
    test_arbitration();
    test_ready_stall();
    test_drop_beats();
    test_reset_midburst();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
